// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, reset vector and the
// fetch packet handed from fetch to decode.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO holding fetched {pc,instr} packets until decode takes them.
// The head entry is presented directly from storage, so it stays stable while stalled.
module fetch_skid_fifo
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  fetch_pkt_t push_data,
   input  logic       pop,
   input  logic       flush,
   output fetch_pkt_t head,
   output logic [1:0] occ
);

   fetch_pkt_t mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic       do_push;
   logic       do_pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && (occ != 2'd0);
   assign do_push = push && ((occ != 2'd2) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (do_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one ROM read per cycle under a
// credit limit, and hands {pc,instr} to decode through a skid FIFO.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
   parameter int              IMEM_BYTES = 4096,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_en,
   output logic [XLEN-1:0] imem_pc,
   input  logic [XLEN-1:0] imem_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr
);

   if (FIFO_DEPTH != 2 || IMEM_BYTES <= 0) begin : g_bad_cfg
      $error("fetch_unit supports only FIFO_DEPTH=2 and a non-empty ROM");
   end

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] req_pc_q;
   logic            inflight_q;
   logic [1:0]      occ;
   fetch_pkt_t      head;
   fetch_pkt_t      push_data;
   logic            pop;
   logic            push;
   logic            issue;
   logic [2:0]      used;
   logic [2:0]      limit;

   // Credits: FIFO entries plus the outstanding read must fit once this cycle's pop leaves.
   assign pop   = out_valid && out_ready;
   assign used  = {1'b0, occ} + {2'b00, inflight_q};
   assign limit = 3'(FIFO_DEPTH) + {2'b00, pop};
   assign issue = !rst && !redirect_valid && (used < limit);

   assign push      = inflight_q && !redirect_valid && !rst;
   assign push_data = '{pc: req_pc_q, instr: imem_instr};

   assign imem_en   = issue;
   assign imem_pc   = rst ? RESET_PC : pc_q;
   assign out_valid = !rst && (occ != 2'd0);
   assign out_pc    = rst ? '0 : head.pc;
   assign out_instr = rst ? '0 : head.instr;

   // A redirect wins over issue; the word returning in that cycle is dropped via push.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
      end else if (redirect_valid) begin
         pc_q       <= word_align(redirect_pc);
         inflight_q <= 1'b0;
      end else if (issue) begin
         req_pc_q   <= pc_q;
         pc_q       <= pc_q + 32'd4;
         inflight_q <= 1'b1;
      end else begin
         inflight_q <= 1'b0;
      end
   end

   fetch_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .occ       (occ)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a ROM model feeds two instances (default
// and high reset vector) while a queue scoreboard checks every accepted packet.
module tb_fetch_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        out_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        imem_en;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   logic        hi_imem_en;
   logic [31:0] hi_imem_pc;
   logic [31:0] hi_imem_instr;
   logic        hi_out_valid;
   logic [31:0] hi_out_pc;
   logic [31:0] hi_out_instr;
   logic        hi_ready = 1'b1;
   logic        hi_redirect_valid = 1'b0;
   logic [31:0] hi_redirect_pc = 32'h0;

   logic [31:0] rom [1024];

   int checks   = 0;
   int failures = 0;

   fetch_pkt_t  sb_q [$];
   fetch_pkt_t  hi_q [$];
   logic [31:0] sb_fill;
   logic [31:0] hi_fill;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_en        (imem_en),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
      .clk            (clk),
      .rst            (rst),
      .imem_en        (hi_imem_en),
      .imem_pc        (hi_imem_pc),
      .imem_instr     (hi_imem_instr),
      .redirect_valid (hi_redirect_valid),
      .redirect_pc    (hi_redirect_pc),
      .out_valid      (hi_out_valid),
      .out_ready      (hi_ready),
      .out_pc         (hi_out_pc),
      .out_instr      (hi_out_instr)
   );

   // Synchronous ROM: registered read, output held while enable is low.
   always @(posedge clk) begin
      if (imem_en) imem_instr <= rom[imem_pc[11:2]];
      if (hi_imem_en) hi_imem_instr <= rom[hi_imem_pc[11:2]];
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic rst_v, input logic ready_v,
                                 input logic redir_v, input logic [31:0] redir_pc_v);
      @(posedge clk);
      #1;
      rst            = rst_v;
      out_ready      = ready_v;
      redirect_valid = redir_v;
      redirect_pc    = redir_pc_v;
      #1;
   endtask

   // Scoreboard: reset and redirect stimulus reload the expected stream; pops in a
   // redirect cycle are still checked against the old stream before the reload.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         hi_q.delete();
         sb_fill = 32'h0000_0000;
         hi_fill = 32'hFFFF_FFF8;
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check_output("sb_underflow", 32'd1, 32'd0);
            end else begin
               fetch_pkt_t e;
               e = sb_q.pop_front();
               check_output("sb_pc", out_pc, e.pc);
               check_output("sb_instr", out_instr, e.instr);
            end
         end
         if (redirect_valid) begin
            sb_q.delete();
            sb_fill = redirect_pc & ~32'h3;
         end
         if (hi_out_valid) begin
            if (hi_q.size() == 0) begin
               check_output("hi_underflow", 32'd1, 32'd0);
            end else begin
               fetch_pkt_t e;
               e = hi_q.pop_front();
               check_output("hi_pc", hi_out_pc, e.pc);
               check_output("hi_instr", hi_out_instr, e.instr);
            end
         end
      end
      while (sb_q.size() < 4) begin
         sb_q.push_back('{pc: sb_fill, instr: rom[sb_fill[11:2]]});
         sb_fill = sb_fill + 32'd4;
      end
      while (hi_q.size() < 4) begin
         hi_q.push_back('{pc: hi_fill, instr: rom[hi_fill[11:2]]});
         hi_fill = hi_fill + 32'd4;
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0000;
      rom[0]     = 32'h0010_0313;
      rom[1]     = 32'h0020_0393;
      rom[4]     = 32'h40A4_8433;
      rom[10'h3FE] = 32'hCAFE_0001;
      rom[10'h3FF] = 32'hCAFE_0002;

      rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      check_output("rst_imem_en", {31'b0, imem_en}, 32'd0);
      check_output("rst_imem_pc", imem_pc, 32'h0);
      check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_output("rst_out_pc", out_pc, 32'h0);
      check_output("rst_out_instr", out_instr, 32'h0);
      check_output("rst_hi_imem_pc", hi_imem_pc, 32'hFFFF_FFF8);

      // Reset release and sequential streaming.
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t1_c0_imem_en", {31'b0, imem_en}, 32'd1);
      check_output("t1_c0_imem_pc", imem_pc, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t1_c1_out_valid", {31'b0, out_valid}, 32'd0);
      check_output("t1_c1_imem_pc", imem_pc, 32'h4);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t1_c2_out_valid", {31'b0, out_valid}, 32'd1);
      check_output("t1_c2_out_pc", out_pc, 32'h0);
      check_output("t1_c2_out_instr", out_instr, 32'h0010_0313);
      check_output("t5_hi_pc0", hi_out_pc, 32'hFFFF_FFF8);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t1_c3_out_pc", out_pc, 32'h4);
      check_output("t1_c3_out_instr", out_instr, 32'h0020_0393);
      check_output("t5_hi_pc1", hi_out_pc, 32'hFFFF_FFFC);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t1_c4_out_pc", out_pc, 32'h8);
      check_output("t5_hi_pc2", hi_out_pc, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t1_c5_out_pc", out_pc, 32'hC);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t1_c6_out_pc", out_pc, 32'h10);
      check_output("t1_c6_out_instr", out_instr, 32'h40A4_8433);

      // Backpressure from the first valid packet.
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      check_output("t2_c1_imem_en", {31'b0, imem_en}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
         check_output("t2_hold_valid", {31'b0, out_valid}, 32'd1);
         check_output("t2_hold_pc", out_pc, 32'h0);
         check_output("t2_hold_imem_en", {31'b0, imem_en}, 32'd0);
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t2_rel_pc0", out_pc, 32'h0);
      check_output("t2_rel_imem_en", {31'b0, imem_en}, 32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t2_rel_valid4", {31'b0, out_valid}, 32'd1);
      check_output("t2_rel_pc4", out_pc, 32'h4);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t2_rel_valid8", {31'b0, out_valid}, 32'd1);
      check_output("t2_rel_pc8", out_pc, 32'h8);

      // Redirect to 0x10 with the FIFO full.
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h10);
      check_output("t3_r_imem_en", {31'b0, imem_en}, 32'd0);
      check_output("t3_r_full_valid", {31'b0, out_valid}, 32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t3_r1_valid", {31'b0, out_valid}, 32'd0);
      check_output("t3_r1_imem_pc", imem_pc, 32'h10);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t3_r2_valid", {31'b0, out_valid}, 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t3_r3_valid", {31'b0, out_valid}, 32'd1);
      check_output("t3_r3_pc", out_pc, 32'h10);
      check_output("t3_r3_instr", out_instr, 32'h40A4_8433);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t3_r4_pc", out_pc, 32'h14);

      // Misaligned redirect target while streaming; the pop in R still counts.
      apply_stimulus(1'b0, 1'b1, 1'b1, 32'h13);
      check_output("t4_r_imem_en", {31'b0, imem_en}, 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t4_r1_valid", {31'b0, out_valid}, 32'd0);
      check_output("t4_r1_imem_pc", imem_pc, 32'h10);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t4_r3_valid", {31'b0, out_valid}, 32'd1);
      check_output("t4_r3_pc", out_pc, 32'h10);

      // One-cycle reset with the FIFO full.
      repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      check_output("t6_full_valid", {31'b0, out_valid}, 32'd1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
      check_output("t6_x_valid", {31'b0, out_valid}, 32'd0);
      check_output("t6_x_imem_en", {31'b0, imem_en}, 32'd0);
      check_output("t6_x_imem_pc", imem_pc, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t6_x1_valid", {31'b0, out_valid}, 32'd0);
      check_output("t6_x1_imem_en", {31'b0, imem_en}, 32'd1);
      check_output("t6_x1_imem_pc", imem_pc, 32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t6_x2_valid", {31'b0, out_valid}, 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t6_x3_valid", {31'b0, out_valid}, 32'd1);
      check_output("t6_x3_pc", out_pc, 32'h0);
      check_output("t6_x3_instr", out_instr, 32'h0010_0313);
      repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
